mdu_hilo: RTL and testbench
===========================

Name: mdu_hilo

Overview:
- Multiply/divide unit with architectural HI/LO registers for the pipelined MIPS core.
- Sits in EX, directly upstream of the EX result-select 4:1 mux; its hi/lo outputs are two of that mux's data inputs (ALU result, HI, LO, PC+8).
- Multi-cycle; exports busy so the hazard unit can stall MFHI/MFLO/MD instructions in ID.

Parameters:
- WIDTH, 32, operand and HI/LO width.
- MULT_CYCLES, 5, busy duration for MULT/MULTU (must be >= 1).
- DIV_CYCLES, 10, busy duration for DIV/DIVU (must be >= 1).

Ports:
- clk  input  1  core clock, rising edge.
- reset  input  1  asynchronous, active-low; 0 clears all state immediately.
- start  input  1  one-cycle request qualifier from EX for md_op.
- md_op  input  3  0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 reserved (treated as NONE).
- rs_val  input  WIDTH  forwarded rs operand.
- rt_val  input  WIDTH  forwarded rt operand.
- busy  output  1  registered; high while a MULT/DIV is in flight.
- hi  output  WIDTH  HI register.
- lo  output  WIDTH  LO register.

Behaviour:
- Reset (reset==0, asynchronous): busy=0, hi=0, lo=0, counter=0, pending result=0, state IDLE.
- State machine with two states, IDLE and RUN:
  - IDLE: at a clk edge with start=1 and md_op in {1..4}, compute the 64-bit result into pending {ph,pl}, load counter = MULT_CYCLES or DIV_CYCLES, set busy=1, go to RUN.
  - IDLE: at a clk edge with start=1 and md_op=5, hi<=rs_val; with md_op=6, lo<=rs_val. Single cycle, busy stays 0.
  - RUN: counter decrements each edge. At the edge where counter reaches 1, hi<=ph, lo<=pl, busy<=0, go to IDLE.
- Latency: an op sampled at edge E gives busy=1 for exactly N cycles, where N is the op's cycle count. New HI/LO and busy=0 are visible after edge E+N.
- start while busy=1 (any op, including MTHI/MTLO): ignored, no state change. The hazard unit stalls on (busy | start&md_op in 1..4); the block itself does not queue.
- MULT: signed 32x32 -> 64; hi=upper word, lo=lower word. MULTU: same, unsigned.
- DIV: lo=quotient truncated toward zero, hi=remainder carrying the dividend's sign.
- DIVU: unsigned quotient and remainder.
- Divisor 0 (DIV/DIVU): the full busy duration still runs; HI/LO are left unchanged at completion.
- DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0.
- md_op NONE/7 with start=1: no effect.
- Reset asserted mid-RUN: operation abandoned, outputs go to reset values, pending result discarded.
- hi/lo are only ever written at IDLE->MTHI/MTLO or RUN completion; they never glitch during RUN.

Decomposition:
- Shared package/header: MD_NONE..MD_MTLO op codes, MULT_CYCLES/DIV_CYCLES defaults, WIDTH.
- One natural sub-module: md_arith, combinational. It takes op, a, b and produces {ph,pl} plus a div_by_zero flag; the signed/unsigned mult/div rules live there.
- The control FSM, counter and HI/LO registers stay in mdu_hilo.

Test Plan:
- MULT rs=0xFFFFFFFE(-2), rt=3 -> busy high 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFA.
- MULTU rs=0xFFFFFFFF, rt=0xFFFFFFFF -> after 5 cycles hi=0xFFFFFFFE, lo=0x00000001.
- DIV rs=-7 (0xFFFFFFF9), rt=2 -> busy 10 cycles; lo=0xFFFFFFFD(-3), hi=0xFFFFFFFF(-1). DIVU 7/2 -> lo=3, hi=1.
- MTHI 0x12345678, then MTLO 0x9ABCDEF0 on consecutive cycles -> each visible the next cycle, busy never asserts. DIV by 0 afterwards -> busy 10 cycles, HI/LO still 0x12345678/0x9ABCDEF0.
- During a MULT in flight: start with MTLO 0xDEAD and with DIVU -> both ignored; final HI/LO equal the MULT result, busy drops at cycle 5.
- Drive reset=0 asynchronously at cycle 3 of a DIV -> busy, hi, lo all 0 immediately. After release, a new MULT 4*5 -> lo=20, hi=0 after 5 cycles.

Source files
------------

// File: rtl/mdu_hilo_pkg.sv
// Shared op codes, default sizing and FSM state type for the HI/LO multiply/divide unit.
package mdu_hilo_pkg;

  localparam int WIDTH_DEF       = 32;
  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;

  typedef enum logic [2:0] {
    MD_NONE  = 3'd0,
    MD_MULT  = 3'd1,
    MD_MULTU = 3'd2,
    MD_DIV   = 3'd3,
    MD_DIVU  = 3'd4,
    MD_MTHI  = 3'd5,
    MD_MTLO  = 3'd6,
    MD_RSVD  = 3'd7
  } md_op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  function automatic logic is_mult(input logic [2:0] op);
    return (op == MD_MULT) || (op == MD_MULTU);
  endfunction

  function automatic logic is_div(input logic [2:0] op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/mdu_hilo_if.sv
// EX-stage request and HI/LO result bundle between the pipeline and the multiply/divide unit.
interface mdu_hilo_if #(parameter int WIDTH = mdu_hilo_pkg::WIDTH_DEF);

  logic             start;
  logic [2:0]       md_op;
  logic [WIDTH-1:0] rs_val;
  logic [WIDTH-1:0] rt_val;
  logic             busy;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (output start, md_op, rs_val, rt_val, input busy, hi, lo);
  modport slave  (input start, md_op, rs_val, rt_val, output busy, hi, lo);

endinterface

// File: rtl/mdu_hilo_md_arith.sv
// Combinational MIPS multiply/divide datapath: 2*WIDTH product, or remainder/quotient as {ph,pl}.
module md_arith
  import mdu_hilo_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic [2:0]       op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] ph_o,
  output logic [WIDTH-1:0] pl_o,
  output logic             div_by_zero_o
);

  logic               sgn;
  logic [2*WIDTH-1:0] ext_a;
  logic [2*WIDTH-1:0] ext_b;
  logic [2*WIDTH-1:0] prod;
  logic               a_neg;
  logic               b_neg;
  logic [WIDTH-1:0]   dvd;
  logic [WIDTH-1:0]   dvs;
  logic [WIDTH-1:0]   dvs_safe;
  logic [WIDTH-1:0]   uq;
  logic [WIDTH-1:0]   ur;
  logic [WIDTH-1:0]   q;
  logic [WIDTH-1:0]   r;

  assign sgn = (op_i == MD_MULT) || (op_i == MD_DIV);

  // Sign-extending to 2*WIDTH makes one unsigned multiplier serve both MULT and MULTU.
  assign ext_a = {{WIDTH{sgn & a_i[WIDTH-1]}}, a_i};
  assign ext_b = {{WIDTH{sgn & b_i[WIDTH-1]}}, b_i};
  assign prod  = ext_a * ext_b;

  // Signed divide runs on magnitudes; 0x80000000 negates to itself and still reads correctly as unsigned.
  assign a_neg    = sgn & a_i[WIDTH-1];
  assign b_neg    = sgn & b_i[WIDTH-1];
  assign dvd      = a_neg ? -a_i : a_i;
  assign dvs      = b_neg ? -b_i : b_i;
  assign dvs_safe = (dvs == '0) ? WIDTH'(1) : dvs;
  assign uq       = dvd / dvs_safe;
  assign ur       = dvd % dvs_safe;
  assign q        = (a_neg ^ b_neg) ? -uq : uq;
  assign r        = a_neg ? -ur : ur;

  assign div_by_zero_o = is_div(op_i) && (b_i == '0);

  always_comb begin
    ph_o = '0;
    pl_o = '0;
    if (is_mult(op_i)) begin
      {ph_o, pl_o} = prod;
    end else if (is_div(op_i)) begin
      ph_o = r;
      pl_o = q;
    end
  end

endmodule

// File: rtl/mdu_hilo.sv
// Multi-cycle MIPS multiply/divide unit owning the architectural HI/LO registers.
// state   | meaning
// IDLE    | accepts MULT/DIV launches and single-cycle MTHI/MTLO
// RUN     | result pending; down-counter runs, start ignored, HI/LO frozen
module mdu_hilo
  import mdu_hilo_pkg::*;
#(
  parameter int WIDTH       = WIDTH_DEF,
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic       clk,
  input  logic       reset,
  mdu_hilo_if.slave  md
);

  localparam int CNT_MAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] ph_q, ph_d;
  logic [WIDTH-1:0] pl_q, pl_d;
  logic             dz_q, dz_d;

  logic [WIDTH-1:0] ar_ph;
  logic [WIDTH-1:0] ar_pl;
  logic             ar_dz;

  md_arith #(.WIDTH(WIDTH)) u_arith (
    .op_i          (md.md_op),
    .a_i           (md.rs_val),
    .b_i           (md.rt_val),
    .ph_o          (ar_ph),
    .pl_o          (ar_pl),
    .div_by_zero_o (ar_dz)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      ph_q    <= '0;
      pl_q    <= '0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      ph_q    <= ph_d;
      pl_q    <= pl_d;
      dz_q    <= dz_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    ph_d    = ph_q;
    pl_d    = pl_q;
    dz_d    = dz_q;
    unique case (state_q)
      ST_IDLE: begin
        if (md.start) begin
          if (is_mult(md.md_op) || is_div(md.md_op)) begin
            ph_d    = ar_ph;
            pl_d    = ar_pl;
            dz_d    = ar_dz;
            cnt_d   = is_mult(md.md_op) ? MULT_LOAD : DIV_LOAD;
            busy_d  = 1'b1;
            state_d = ST_RUN;
          end else if (md.md_op == MD_MTHI) begin
            hi_d = md.rs_val;
          end else if (md.md_op == MD_MTLO) begin
            lo_d = md.rs_val;
          end
        end
      end
      ST_RUN: begin
        // Terminal count of 1 means this edge closes the Nth busy cycle.
        if (cnt_q == CNT_W'(1)) begin
          cnt_d   = '0;
          busy_d  = 1'b0;
          state_d = ST_IDLE;
          if (!dz_q) begin
            hi_d = ph_q;
            lo_d = pl_q;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign md.busy = busy_q;
  assign md.hi   = hi_q;
  assign md.lo   = lo_q;

endmodule

// File: tb/tb_mdu_hilo.sv
// Directed-vector bench for mdu_hilo: table of MULT/DIV results plus hand sequences for MT*, ignored starts and reset.
module tb_mdu_hilo;

  logic clk;
  logic reset;
  int   n_total;
  int   n_pass;

  mdu_hilo_if #(.WIDTH(32)) md ();

  mdu_hilo #(.WIDTH(32), .MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk   (clk),
    .reset (reset),
    .md    (md)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] rs;
    logic [31:0] rt;
    int          n;
    logic [31:0] ehi;
    logic [31:0] elo;
    string       name;
  } vec_t;

  vec_t vecs[11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  task automatic run_md(input logic [2:0] op, input logic [31:0] rs, input logic [31:0] rt,
                        input int n, input logic [31:0] ehi, input logic [31:0] elo,
                        input string name);
    int c;
    @(negedge clk);
    md.start = 1'b1; md.md_op = op; md.rs_val = rs; md.rt_val = rt;
    @(posedge clk); #1;
    md.start = 1'b0; md.md_op = 3'd0;
    c = 0;
    while (md.busy === 1'b1 && c < 40) begin
      c++;
      @(posedge clk); #1;
    end
    check({name, " busy_cycles"}, 32'(c), 32'(n));
    check({name, " hi"}, md.hi, ehi);
    check({name, " lo"}, md.lo, elo);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int c;
    n_total = 0;
    n_pass  = 0;
    vecs[0]  = '{3'd1, 32'hFFFF_FFFE, 32'h0000_0003,  5, 32'hFFFF_FFFF, 32'hFFFF_FFFA, "mult_neg2x3"};
    vecs[1]  = '{3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF,  5, 32'hFFFF_FFFE, 32'h0000_0001, "multu_max"};
    vecs[2]  = '{3'd3, 32'hFFFF_FFF9, 32'h0000_0002, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD, "div_neg7_2"};
    vecs[3]  = '{3'd4, 32'h0000_0007, 32'h0000_0002, 10, 32'h0000_0001, 32'h0000_0003, "divu_7_2"};
    vecs[4]  = '{3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 10, 32'h0000_0000, 32'h8000_0000, "div_min_neg1"};
    vecs[5]  = '{3'd1, 32'h8000_0000, 32'h8000_0000,  5, 32'h4000_0000, 32'h0000_0000, "mult_min_sq"};
    vecs[6]  = '{3'd2, 32'h8000_0000, 32'h0000_0002,  5, 32'h0000_0001, 32'h0000_0000, "multu_carry"};
    vecs[7]  = '{3'd3, 32'h0000_0007, 32'hFFFF_FFFE, 10, 32'h0000_0001, 32'hFFFF_FFFD, "div_7_neg2"};
    vecs[8]  = '{3'd4, 32'hFFFF_FFFF, 32'h0000_0010, 10, 32'h0000_000F, 32'h0FFF_FFFF, "divu_max_16"};
    vecs[9]  = '{3'd3, 32'hFFFF_FFF8, 32'hFFFF_FFFD, 10, 32'hFFFF_FFFE, 32'h0000_0002, "div_neg8_neg3"};
    vecs[10] = '{3'd1, 32'h7FFF_FFFF, 32'hFFFF_FFFF,  5, 32'hFFFF_FFFF, 32'h8000_0001, "mult_max_neg1"};

    reset = 1'b0;
    md.start = 1'b0; md.md_op = 3'd0; md.rs_val = '0; md.rt_val = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset busy", {31'd0, md.busy}, 32'd0);
    check("reset hi", md.hi, 32'd0);
    check("reset lo", md.lo, 32'd0);
    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < 11; i++)
      run_md(vecs[i].op, vecs[i].rs, vecs[i].rt, vecs[i].n, vecs[i].ehi, vecs[i].elo, vecs[i].name);

    // MTHI then MTLO back to back, each visible one edge later with busy low.
    @(negedge clk);
    md.start = 1'b1; md.md_op = 3'd5; md.rs_val = 32'h1234_5678;
    @(posedge clk); #1;
    check("mthi hi", md.hi, 32'h1234_5678);
    check("mthi busy", {31'd0, md.busy}, 32'd0);
    @(negedge clk);
    md.md_op = 3'd6; md.rs_val = 32'h9ABC_DEF0;
    @(posedge clk); #1;
    check("mtlo lo", md.lo, 32'h9ABC_DEF0);
    check("mtlo hi", md.hi, 32'h1234_5678);
    check("mtlo busy", {31'd0, md.busy}, 32'd0);

    // NONE and reserved op codes with start are no-ops.
    @(negedge clk);
    md.md_op = 3'd0; md.rs_val = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    check("none busy", {31'd0, md.busy}, 32'd0);
    @(negedge clk);
    md.md_op = 3'd7;
    @(posedge clk); #1;
    check("rsvd busy", {31'd0, md.busy}, 32'd0);
    check("rsvd hi", md.hi, 32'h1234_5678);
    check("rsvd lo", md.lo, 32'h9ABC_DEF0);
    @(negedge clk);
    md.start = 1'b0; md.md_op = 3'd0;

    run_md(3'd3, 32'h0000_0005, 32'h0000_0000, 10, 32'h1234_5678, 32'h9ABC_DEF0, "div_by_zero");

    // MULT in flight; MTLO and DIVU launched during RUN must be dropped.
    @(negedge clk);
    md.start = 1'b1; md.md_op = 3'd1; md.rs_val = 32'h0001_2345; md.rt_val = 32'h0001_0001;
    @(posedge clk); #1;
    c = (md.busy === 1'b1) ? 1 : 0;
    @(negedge clk);
    md.md_op = 3'd6; md.rs_val = 32'h0000_DEAD;
    @(posedge clk); #1;
    if (md.busy === 1'b1) c++;
    check("inflight mtlo lo", md.lo, 32'h9ABC_DEF0);
    @(negedge clk);
    md.md_op = 3'd4; md.rs_val = 32'd100; md.rt_val = 32'd7;
    @(posedge clk); #1;
    if (md.busy === 1'b1) c++;
    check("inflight hi", md.hi, 32'h1234_5678);
    @(negedge clk);
    md.start = 1'b0; md.md_op = 3'd0;
    for (int i = 0; i < 40 && md.busy === 1'b1; i++) begin
      @(posedge clk); #1;
      if (md.busy === 1'b1) c++;
    end
    check("inflight busy_cycles", 32'(c), 32'd5);
    check("inflight hi result", md.hi, 32'h0000_0001);
    check("inflight lo result", md.lo, 32'h2346_2345);
    @(posedge clk); #1;
    check("inflight no queue", {31'd0, md.busy}, 32'd0);

    // Asynchronous reset in the third cycle of a DIV.
    @(negedge clk);
    md.start = 1'b1; md.md_op = 3'd3; md.rs_val = 32'd100; md.rt_val = 32'd3;
    @(posedge clk); #1;
    md.start = 1'b0; md.md_op = 3'd0;
    check("div pre-reset busy", {31'd0, md.busy}, 32'd1);
    @(posedge clk);
    @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    check("async reset busy", {31'd0, md.busy}, 32'd0);
    check("async reset hi", md.hi, 32'd0);
    check("async reset lo", md.lo, 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    check("post-reset busy", {31'd0, md.busy}, 32'd0);
    check("post-reset lo", md.lo, 32'd0);

    run_md(3'd1, 32'd4, 32'd5, 5, 32'd0, 32'd20, "mult_4x5");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
